// File: rtl/l2_arbiter.sv
// l2_arbiter: shares the single unified L2 port between the I-cache and D-cache miss paths.
// Latency: a request seen in IDLE at cycle N drives mem_* at N+1; mem_resp is forwarded with zero added latency.
// Backpressure: one L2 transaction in flight; the loser holds its request; one idle L2 cycle follows every mem_resp.
module l2_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256,
    parameter int FIXED_PRIO = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] i_address,
    input  logic                  i_read,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp,
    output logic [31:0]           i_grant_cnt,
    output logic [31:0]           d_grant_cnt
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  rd;
        logic                  wr;
        logic [LINE_WIDTH-1:0] wdata;
    } req_t;

    localparam bit D_PRIO = (FIXED_PRIO != 0);

    state_t      state, state_nxt;
    logic        last_grant, last_grant_nxt;
    req_t        lat, lat_nxt;
    logic [31:0] i_cnt, d_cnt;
    logic        req_i, req_d, grant_i, grant_d;
    logic        serving;

    assign req_i = i_read;
    assign req_d = d_read | d_write;

    // On conflict D wins under fixed priority, or when I held the last grant.
    assign grant_d = req_d && (!req_i || D_PRIO || !last_grant);
    assign grant_i = req_i && !grant_d;

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        lat_nxt        = lat;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nxt      = SERVE_D;
                    last_grant_nxt = 1'b1;
                    lat_nxt.addr   = d_address;
                    // read+write together is illegal and is served as a write
                    lat_nxt.rd     = d_read & ~d_write;
                    lat_nxt.wr     = d_write;
                    lat_nxt.wdata  = d_wdata;
                end else if (grant_i) begin
                    state_nxt      = SERVE_I;
                    last_grant_nxt = 1'b0;
                    lat_nxt.addr   = i_address;
                    lat_nxt.rd     = 1'b1;
                    lat_nxt.wr     = 1'b0;
                    lat_nxt.wdata  = '0;
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem_resp) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            lat        <= '0;
            i_cnt      <= '0;
            d_cnt      <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            lat        <= lat_nxt;
            if (i_resp) begin
                i_cnt <= i_cnt + 32'd1;
            end
            if (d_resp) begin
                d_cnt <= d_cnt + 32'd1;
            end
        end
    end

    assign serving     = (state != IDLE);
    assign mem_address = lat.addr;
    assign mem_read    = serving & lat.rd;
    assign mem_write   = serving & lat.wr;
    assign mem_wdata   = lat.wdata;

    assign i_resp  = (state == SERVE_I) & mem_resp;
    assign d_resp  = (state == SERVE_D) & mem_resp;
    assign i_rdata = i_resp ? mem_rdata : '0;
    assign d_rdata = d_resp ? mem_rdata : '0;

    assign i_grant_cnt = i_cnt;
    assign d_grant_cnt = d_cnt;

endmodule

// File: tb/tb_l2_arbiter.sv
// Bench for l2_arbiter: instance 0 is round-robin, instance 1 is fixed D priority.
module tb_l2_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] i_address [2];
    logic [AW-1:0] d_address [2];
    logic [AW-1:0] mem_address [2];
    logic          i_read [2], d_read [2], d_write [2];
    logic          i_resp [2], d_resp [2];
    logic          mem_read [2], mem_write [2], mem_resp [2];
    logic [LW-1:0] i_rdata [2], d_rdata [2], d_wdata [2];
    logic [LW-1:0] mem_wdata [2], mem_rdata [2];
    logic [31:0]   i_grant_cnt [2], d_grant_cnt [2];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    l2_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .FIXED_PRIO(0)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .i_address(i_address[0]), .i_read(i_read[0]), .i_rdata(i_rdata[0]), .i_resp(i_resp[0]),
        .d_address(d_address[0]), .d_read(d_read[0]), .d_write(d_write[0]), .d_wdata(d_wdata[0]),
        .d_rdata(d_rdata[0]), .d_resp(d_resp[0]),
        .mem_address(mem_address[0]), .mem_read(mem_read[0]), .mem_write(mem_write[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .mem_resp(mem_resp[0]),
        .i_grant_cnt(i_grant_cnt[0]), .d_grant_cnt(d_grant_cnt[0])
    );

    l2_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .i_address(i_address[1]), .i_read(i_read[1]), .i_rdata(i_rdata[1]), .i_resp(i_resp[1]),
        .d_address(d_address[1]), .d_read(d_read[1]), .d_write(d_write[1]), .d_wdata(d_wdata[1]),
        .d_rdata(d_rdata[1]), .d_resp(d_resp[1]),
        .mem_address(mem_address[1]), .mem_read(mem_read[1]), .mem_write(mem_write[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .mem_resp(mem_resp[1]),
        .i_grant_cnt(i_grant_cnt[1]), .d_grant_cnt(d_grant_cnt[1])
    );

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] rnd_line();
        logic [LW-1:0] v;
        for (int w = 0; w < LW / 32; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic idle_inputs();
        for (int k = 0; k < 2; k++) begin
            i_address[k] = '0; i_read[k] = 1'b0;
            d_address[k] = '0; d_read[k] = 1'b0; d_write[k] = 1'b0; d_wdata[k] = '0;
            mem_rdata[k] = '0; mem_resp[k] = 1'b0;
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Caller sits 1ns after a falling edge; returns at the falling edge after the response cycle.
    task automatic expect_txn(input int k, input bit exp_d, input logic [AW-1:0] exp_addr,
                              input bit exp_wr, input logic [LW-1:0] exp_wd, input string tag);
        int n = 0;
        logic [LW-1:0] rd;
        while (!(mem_read[k] || mem_write[k]) && n < 10) begin
            @(negedge clk); #1;
            n++;
        end
        chk({tag, "_seen"}, mem_read[k] | mem_write[k], 1'b1);
        chk({tag, "_addr"}, mem_address[k], exp_addr);
        chk({tag, "_wr"}, mem_write[k], exp_wr);
        chk({tag, "_rd"}, mem_read[k], !exp_wr);
        if (exp_wr) chk({tag, "_wdata"}, mem_wdata[k], exp_wd);
        rd = rnd_line();
        mem_rdata[k] = rd;
        mem_resp[k]  = 1'b1;
        #1;
        chk({tag, "_iresp"}, i_resp[k], !exp_d);
        chk({tag, "_dresp"}, d_resp[k], exp_d);
        chk({tag, "_rdata"}, exp_d ? d_rdata[k] : i_rdata[k], rd);
        @(negedge clk);
        mem_resp[k]  = 1'b0;
        mem_rdata[k] = '0;
    endtask

    // Transaction-level reference: who is granted, what L2 must see, what each side must get back.
    task automatic random_run(input int k, input int cycles);
        bit            busy = 0, owner = 0, last = 1;
        logic [AW-1:0] m_addr = '0;
        bit            m_rd = 0, m_wr = 0;
        logic [LW-1:0] m_wd = '0;
        int            wait_left = 0, icnt = 0, dcnt = 0;
        bit            i_pend = 0, d_pend = 0;
        int            d_op = 0;
        bit            winner;
        do_reset();
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (!i_pend && $urandom_range(0, 2) == 0) i_pend = 1;
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1;
                d_op   = ($urandom_range(0, 7) == 0) ? 2 : int'($urandom_range(0, 1));
            end
            i_read[k]    = i_pend;
            d_read[k]    = d_pend && (d_op != 1);
            d_write[k]   = d_pend && (d_op != 0);
            i_address[k] = $urandom;
            d_address[k] = $urandom;
            d_wdata[k]   = rnd_line();
            mem_rdata[k] = rnd_line();
            mem_resp[k]  = busy ? (wait_left == 0) : ($urandom_range(0, 7) == 0);
            #1;
            chk("rnd_mr", mem_read[k], busy && m_rd);
            chk("rnd_mw", mem_write[k], busy && m_wr);
            if (busy) begin
                chk("rnd_addr", mem_address[k], m_addr);
                chk("rnd_wdata", mem_wdata[k], m_wd);
            end
            chk("rnd_iresp", i_resp[k], busy && mem_resp[k] && !owner);
            chk("rnd_dresp", d_resp[k], busy && mem_resp[k] && owner);
            chk("rnd_irdata", i_rdata[k], (busy && mem_resp[k] && !owner) ? mem_rdata[k] : '0);
            chk("rnd_drdata", d_rdata[k], (busy && mem_resp[k] && owner) ? mem_rdata[k] : '0);
            chk("rnd_icnt", i_grant_cnt[k], icnt);
            chk("rnd_dcnt", d_grant_cnt[k], dcnt);
            if (busy) begin
                if (mem_resp[k]) begin
                    busy = 0;
                    if (owner) begin dcnt++; d_pend = 0; end
                    else begin icnt++; i_pend = 0; end
                end else begin
                    wait_left--;
                end
            end else if (i_pend || d_pend) begin
                if (i_pend && d_pend) winner = (k == 1) ? 1'b1 : !last;
                else winner = d_pend;
                busy      = 1;
                owner     = winner;
                last      = winner;
                wait_left = $urandom_range(0, 3);
                m_addr    = winner ? d_address[k] : i_address[k];
                m_rd      = winner ? (d_op == 0) : 1'b1;
                m_wr      = winner ? (d_op != 0) : 1'b0;
                m_wd      = winner ? d_wdata[k] : '0;
            end
        end
        idle_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 1000000", $time);
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] ia, da;
        logic [LW-1:0] w1, w2;
        bit            prev_mr, prev_resp;

        // Reset state and a single I read
        do_reset();
        for (int k = 0; k < 2; k++) begin
            chk("rst_mr", mem_read[k], 1'b0);
            chk("rst_mw", mem_write[k], 1'b0);
            chk("rst_addr", mem_address[k], '0);
            chk("rst_icnt", i_grant_cnt[k], '0);
            chk("rst_dcnt", d_grant_cnt[k], '0);
        end
        @(negedge clk); i_read[0] = 1; i_address[0] = 32'h0040_0020; #1;
        chk("si_c0_mr", mem_read[0], 1'b0);
        @(negedge clk); #1;
        chk("si_c1_mr", mem_read[0], 1'b1);
        chk("si_c1_addr", mem_address[0], 32'h0040_0020);
        @(negedge clk); #1;
        chk("si_c2_mr", mem_read[0], 1'b1);
        chk("si_c2_iresp", i_resp[0], 1'b0);
        @(negedge clk); mem_resp[0] = 1; mem_rdata[0] = {32{8'hAA}}; #1;
        chk("si_iresp", i_resp[0], 1'b1);
        chk("si_irdata", i_rdata[0], {32{8'hAA}});
        chk("si_dresp", d_resp[0], 1'b0);
        chk("si_drdata", d_rdata[0], '0);
        @(negedge clk); mem_resp[0] = 0; i_read[0] = 0; #1;
        chk("si_post_iresp", i_resp[0], 1'b0);
        chk("si_post_mr", mem_read[0], 1'b0);
        chk("si_icnt", i_grant_cnt[0], 32'd1);

        // Asynchronous reset in the middle of a D write-back
        w1 = rnd_line();
        @(negedge clk); d_write[0] = 1; d_address[0] = 32'h300; d_wdata[0] = w1; #1;
        @(negedge clk); #1;
        chk("ar_pre_mw", mem_write[0], 1'b1);
        chk("ar_pre_wdata", mem_wdata[0], w1);
        rst_n = 0; #1;
        chk("ar_mw", mem_write[0], 1'b0);
        chk("ar_wdata", mem_wdata[0], '0);
        chk("ar_addr", mem_address[0], '0);
        chk("ar_icnt", i_grant_cnt[0], '0);
        @(negedge clk); d_write[0] = 0; d_wdata[0] = '0;
        @(negedge clk); rst_n = 1; i_read[0] = 1; i_address[0] = 32'h0000_1000;
        mem_resp[0] = 1; mem_rdata[0] = rnd_line(); #1;
        chk("ar_late_iresp", i_resp[0], 1'b0);
        chk("ar_late_dresp", d_resp[0], 1'b0);
        chk("ar_late_rdata", i_rdata[0], '0);
        chk("ar_c1_mr", mem_read[0], 1'b0);
        @(negedge clk); mem_resp[0] = 0; #1;
        chk("ar_c2_mr", mem_read[0], 1'b1);
        chk("ar_c2_addr", mem_address[0], 32'h0000_1000);
        chk("ar_c2_dcnt", d_grant_cnt[0], '0);
        expect_txn(0, 0, 32'h0000_1000, 0, '0, "ar_txn");
        i_read[0] = 0; #1;
        chk("ar_icnt_done", i_grant_cnt[0], 32'd1);

        // Round-robin conflict: both held through four grants alternate I, D, I, D
        do_reset();
        w2 = rnd_line();
        @(negedge clk);
        i_read[0] = 1; i_address[0] = 32'h1111_0000;
        d_write[0] = 1; d_address[0] = 32'h2222_0000; d_wdata[0] = w2; #1;
        expect_txn(0, 0, 32'h1111_0000, 0, '0, "rr1_i"); #1;
        expect_txn(0, 1, 32'h2222_0000, 1, w2, "rr2_d"); #1;
        expect_txn(0, 0, 32'h1111_0000, 0, '0, "rr3_i"); #1;
        expect_txn(0, 1, 32'h2222_0000, 1, w2, "rr4_d");
        i_read[0] = 0; d_write[0] = 0; #1;
        chk("rr_icnt", i_grant_cnt[0], 32'd2);
        chk("rr_dcnt", d_grant_cnt[0], 32'd2);

        // Fixed priority: every simultaneous pair serves D first
        do_reset();
        for (int p = 0; p < 4; p++) begin
            ia = $urandom; da = $urandom;
            @(negedge clk);
            i_read[1] = 1; i_address[1] = ia;
            d_read[1] = 1; d_address[1] = da; #1;
            expect_txn(1, 1, da, 0, '0, "fp_d");
            d_read[1] = 0; #1;
            expect_txn(1, 0, ia, 0, '0, "fp_i");
            i_read[1] = 0;
        end
        #1;
        chk("fp_icnt", i_grant_cnt[1], 32'd4);
        chk("fp_dcnt", d_grant_cnt[1], 32'd4);

        // Held request: address change mid-transaction does not reach L2
        do_reset();
        @(negedge clk); d_read[0] = 1; d_address[0] = 32'h100; #1;
        @(negedge clk); #1;
        chk("held_c1_addr", mem_address[0], 32'h100);
        d_address[0] = 32'h200;
        @(negedge clk); #1;
        chk("held_c2_addr", mem_address[0], 32'h100);
        expect_txn(0, 1, 32'h100, 0, '0, "held");
        d_read[0] = 0;

        // Back-to-back hits: L2 answers the cycle after it first sees the request
        do_reset();
        prev_mr = 0; prev_resp = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            i_read[0] = 1; i_address[0] = 32'h0000_4000;
            mem_resp[0] = prev_mr && !prev_resp;
            mem_rdata[0] = rnd_line();
            #1;
            chk("b2b_mr", mem_read[0], (c % 3) != 0);
            chk("b2b_iresp", i_resp[0], (c % 3) == 2);
            prev_resp = mem_resp[0];
            prev_mr   = mem_read[0];
        end
        @(negedge clk); i_read[0] = 0; mem_resp[0] = 0; #1;
        chk("b2b_icnt", i_grant_cnt[0], 32'd4);

        random_run(0, 400);
        random_run(1, 400);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
